serial_operand_pair_serializer: RTL

- Transmit side of the two-operand serial-bit interface used by the serial comparators.
- Accepts a pair of WIDTH-bit operands over a valid/ready handshake and emits them one bit per beat on a and b, in lockstep.
- Bit order is MSB-first or LSB-first, selected per frame.
- Adds first/last framing and out_valid/out_ready backpressure so downstream serial consumers can be fed continuously.

---
 rtl/serial_operand_pair_serializer.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/serial_operand_pair_serializer.sv
// serial_operand_pair_serializer
// Transmit side of the two-operand serial-bit link. It takes a pair of WIDTH-bit
// operands over a valid/ready handshake and plays them out one bit per beat on
// a/b in lockstep. Each frame is marked with first/last, the bit order (MSB-first
// or LSB-first) is chosen per frame, and out_ready applies backpressure.
module serial_operand_pair_serializer #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic             msb_first,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             a,
  output logic             b,
  output logic             first,
  output logic             last
);

  // The counter needs at least one bit, even when WIDTH is 1.
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_IDX = CW'(WIDTH - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [CW-1:0]    cnt_nxt;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic             msb_q, msb_d;
  logic             out_valid_q, out_valid_d;
  logic             a_q, a_d;
  logic             b_q, b_d;
  logic             first_q, first_d;
  logic             last_q, last_d;
  logic             accept;
  logic             xfer;

  // The block is ready when it is idle, or on the final beat of a frame when
  // that beat is being taken. The second case lets frames run back to back.
  always_comb begin
    in_ready = rst & ((state_q == IDLE) | ((state_q == SHIFT) & last_q & out_ready));
    accept   = in_valid & in_ready;
    xfer     = out_valid_q & out_ready;
  end

  // Next-state logic. Each beat's bit is decided one edge ahead and held in a
  // flop, so a/b/first/last have no combinational path from any input. The
  // shift registers hold the bits that have not been sent yet, and each beat
  // shifts out from whichever end the frame's bit order selects.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    a_sh_d      = a_sh_q;
    b_sh_d      = b_sh_q;
    msb_d       = msb_q;
    out_valid_d = out_valid_q;
    a_d         = a_q;
    b_d         = b_q;
    first_d     = first_q;
    last_d      = last_q;
    cnt_nxt     = cnt_q + CW'(1);

    if (accept) begin
      state_d     = SHIFT;
      cnt_d       = '0;
      msb_d       = msb_first;
      out_valid_d = 1'b1;
      first_d     = 1'b1;
      last_d      = (WIDTH == 1);
      if (msb_first) begin
        a_d    = a_in[WIDTH-1];
        b_d    = b_in[WIDTH-1];
        a_sh_d = a_in << 1;
        b_sh_d = b_in << 1;
      end else begin
        a_d    = a_in[0];
        b_d    = b_in[0];
        a_sh_d = a_in >> 1;
        b_sh_d = b_in >> 1;
      end
    end else if (xfer) begin
      if (last_q) begin
        state_d     = IDLE;
        cnt_d       = '0;
        out_valid_d = 1'b0;
        a_d         = 1'b0;
        b_d         = 1'b0;
        first_d     = 1'b0;
        last_d      = 1'b0;
      end else begin
        cnt_d   = cnt_nxt;
        first_d = 1'b0;
        last_d  = (cnt_nxt == LAST_IDX);
        if (msb_q) begin
          a_d    = a_sh_q[WIDTH-1];
          b_d    = b_sh_q[WIDTH-1];
          a_sh_d = a_sh_q << 1;
          b_sh_d = b_sh_q << 1;
        end else begin
          a_d    = a_sh_q[0];
          b_d    = b_sh_q[0];
          a_sh_d = a_sh_q >> 1;
          b_sh_d = b_sh_q >> 1;
        end
      end
    end
  end

  // State register. A synchronous active-low reset drops any frame in flight.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      a_sh_q      <= '0;
      b_sh_q      <= '0;
      msb_q       <= 1'b0;
      out_valid_q <= 1'b0;
      a_q         <= 1'b0;
      b_q         <= 1'b0;
      first_q     <= 1'b0;
      last_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      a_sh_q      <= a_sh_d;
      b_sh_q      <= b_sh_d;
      msb_q       <= msb_d;
      out_valid_q <= out_valid_d;
      a_q         <= a_d;
      b_q         <= b_d;
      first_q     <= first_d;
      last_q      <= last_d;
    end
  end

  // Output ports are driven straight from their flops.
  always_comb begin
    out_valid = out_valid_q;
    a         = a_q;
    b         = b_q;
    first     = first_q;
    last      = last_q;
  end

endmodule
